// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared types and constants for the pipeline control blocks
package pipeline_pkg;
  typedef enum logic {RUN, MD_BUSY} md_state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MD_LAT_DEF = 4;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational hazard and redirect decision for the ID stage
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_branch_taken,
  input  logic       id_is_jump,
  input  logic       id_is_muldiv,
  input  logic       id_reads_hilo,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       md_busy,
  output logic       hz,
  output logic       redirect
);
  logic rs_dep, rt_dep, ex_match, mem_match, id_cmp;
  logic load_use, br_ex, br_mem, md_hz;
  assign rs_dep    = id_uses_rs && id_rs != REG_ZERO;
  assign rt_dep    = id_uses_rt && id_rt != REG_ZERO;
  assign ex_match  = (rs_dep && ex_rd == id_rs) || (rt_dep && ex_rd == id_rt);
  assign mem_match = (rs_dep && mem_rd == id_rs) || (rt_dep && mem_rd == id_rt);
  // only j/jal/jr raise id_is_jump; jr is the one that reads rs, so rs_dep isolates it
  assign id_cmp    = id_is_branch || id_is_jump;
  assign load_use  = ex_mem_read && ex_match;
  assign br_ex     = id_cmp && ex_reg_write && ex_rd != REG_ZERO && ex_match;
  assign br_mem    = id_cmp && mem_mem_read && mem_match;
  assign md_hz     = md_busy && (id_is_muldiv || id_reads_hilo);
  assign hz        = load_use || br_ex || br_mem || md_hz;
  assign redirect  = !hz && (id_is_jump || (id_is_branch && id_branch_taken));
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline stall/flush sequencer with mul/div busy window
// and a saturating stall-cycle counter.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_branch_taken,
  input  logic             id_is_jump,
  input  logic             id_is_muldiv,
  input  logic             id_reads_hilo,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_rd,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  output logic             stall,
  output logic             flush,
  output logic             PCsrc,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);
  md_state_t  state;
  logic [3:0] md_cnt;
  logic       hz, redirect, issue;
  hazard_detect u_detect (
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .md_busy(md_busy), .hz(hz), .redirect(redirect)
  );
  assign stall        = hz;
  assign id_ex_bubble = hz;
  assign flush        = redirect;
  assign PCsrc        = redirect;
  assign md_busy      = state == MD_BUSY;
  assign issue        = state == RUN && id_is_muldiv && !hz;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      md_cnt      <= '0;
      md_done     <= 1'b0;
      stall_count <= '0;
    end else begin
      if (stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      // md_done is registered: it is asserted for the cycle in which md_cnt will read 1
      md_done <= state == RUN ? issue && MD_LAT == 1 : md_cnt == 4'd2;
      if (state == RUN) begin
        if (issue) begin
          state  <= MD_BUSY;
          md_cnt <= 4'(MD_LAT);
        end
      end else begin
        md_cnt <= md_cnt - 1'b1;
        if (md_cnt == 4'd1) state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;
  localparam int CW = 3;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump;
  logic id_is_muldiv, id_reads_hilo, ex_mem_read, ex_reg_write, mem_mem_read;
  logic stall, flush, PCsrc, id_ex_bubble, md_busy, md_done;
  logic [CW-1:0] stall_count;
  typedef struct {
    string tag;
    logic st, fl, busy, done;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb[$];
  int n_vec = 0, n_bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  hazard_control_unit #(.MD_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken),
    .id_is_jump(id_is_jump), .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .stall(stall), .flush(flush), .PCsrc(PCsrc),
    .id_ex_bubble(id_ex_bubble), .md_busy(md_busy), .md_done(md_done), .stall_count(stall_count)
  );
  always #5 clk = ~clk;
  task automatic clear();
    {id_rs, id_rt, ex_rd, mem_rd} = '0;
    {id_uses_rs, id_uses_rt, id_is_branch, id_branch_taken, id_is_jump} = '0;
    {id_is_muldiv, id_reads_hilo, ex_mem_read, ex_reg_write, mem_mem_read} = '0;
  endtask
  task automatic cmp(string tag, string sig, logic [7:0] obs, logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, sig, obs, exp);
    end
  endtask
  task automatic check(string tag, logic st, logic fl, logic busy, logic done);
    exp_t e;
    sb.push_back('{tag, st, fl, busy, done, exp_cnt});
    #1;
    e = sb.pop_front();
    cmp(e.tag, "stall", 8'(stall), 8'(e.st));
    cmp(e.tag, "id_ex_bubble", 8'(id_ex_bubble), 8'(e.st));
    cmp(e.tag, "flush", 8'(flush), 8'(e.fl));
    cmp(e.tag, "PCsrc", 8'(PCsrc), 8'(e.fl));
    cmp(e.tag, "md_busy", 8'(md_busy), 8'(e.busy));
    cmp(e.tag, "md_done", 8'(md_done), 8'(e.done));
    cmp(e.tag, "stall_count", 8'(stall_count), 8'(e.cnt));
    if (e.st && !(&exp_cnt)) exp_cnt++;
  endtask
  initial begin
    clear();
    @(negedge clk);
    check("reset", 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk); clear();
    ex_mem_read = 1; ex_rd = 8; id_rs = 8; id_uses_rs = 1;
    check("load_use", 1, 0, 0, 0);
    @(negedge clk); clear();
    check("after_lu", 0, 0, 0, 0);
    @(negedge clk); clear();
    ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    check("zero_reg", 0, 0, 0, 0);
    @(negedge clk); clear();
    ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    check("alu_fwd", 0, 0, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1;
    check("br_taken", 0, 1, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1;
    check("br_not_taken", 0, 0, 0, 0);
    @(negedge clk); clear();
    id_is_jump = 1;
    check("jump", 0, 1, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1; id_rt = 9; id_uses_rt = 1;
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
    check("br_ld_ex", 1, 0, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1; id_rt = 9; id_uses_rt = 1;
    mem_mem_read = 1; mem_rd = 9;
    check("br_ld_mem", 1, 0, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1; id_rt = 9; id_uses_rt = 1;
    check("br_ld_go", 0, 1, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1; id_rs = 5; id_uses_rs = 1;
    ex_reg_write = 1; ex_rd = 5;
    check("br_alu", 1, 0, 0, 0);
    @(negedge clk); clear();
    id_is_branch = 1; id_branch_taken = 1; id_rs = 5; id_uses_rs = 1;
    check("br_alu_go", 0, 1, 0, 0);
    @(negedge clk); clear();
    id_is_jump = 1; id_rs = 31; id_uses_rs = 1; ex_reg_write = 1; ex_rd = 31;
    check("jr_alu", 1, 0, 0, 0);
    @(negedge clk); clear();
    id_is_muldiv = 1;
    check("md_issue", 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); clear();
      id_reads_hilo = 1;
      check($sformatf("md_wait%0d", i), 1, 0, 1, i == 4);
    end
    @(negedge clk); clear();
    id_reads_hilo = 1;
    check("md_release", 0, 0, 0, 0);
    @(negedge clk); clear();
    id_is_muldiv = 1;
    check("md_issue2", 0, 0, 0, 0);
    @(negedge clk); clear();
    id_is_muldiv = 1;
    check("md_busy_md", 1, 0, 1, 0);
    @(negedge clk); clear();
    reset = 1'b1;
    exp_cnt = '0;
    check("async_rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); clear();
      check($sformatf("post_rst%0d", i), 0, 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Central pipeline sequencer for the 5-stage core. Each cycle it decides whether fetch advances, stalls or is flushed. It drives `stall` to the PC and IF/ID register, `flush` to IF/ID, `PCsrc` to the PC mux, and `id_ex_bubble` to the ID/EX register. It also owns the busy window of the multi-cycle multiply/divide unit and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- `MD_LAT`, 4: mul/div latency in cycles; legal range 1..15.
- `CNT_W`, 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: asynchronous, active-high reset.
- `id_rs`, `id_rt`  in  5: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt`  in  1: the ID instruction really reads rs / rt.
- `id_is_branch`  in  1: conditional branch; it is compared in ID.
- `id_branch_taken`  in  1: ID comparator result; only valid with `id_is_branch`.
- `id_is_jump`  in  1: j/jal/jr in ID.
- `id_is_muldiv`  in  1: mult/div in ID.
- `id_reads_hilo`  in  1: mfhi/mflo in ID.
- `ex_mem_read`, `ex_reg_write`  in  1: control bits of the instruction in EX.
- `ex_rd`  in  5: destination register of EX.
- `mem_mem_read`  in  1: the instruction in MEM is a load.
- `mem_rd`  in  5: destination register of MEM.
- `stall`  out  1: hold PC and IF/ID.
- `flush`  out  1: clear IF/ID to nop.
- `PCsrc`  out  1: 1 selects `pc_decode_jump`.
- `id_ex_bubble`  out  1: load nop into ID/EX.
- `md_busy`  out  1: mul/div unit is occupied.
- `md_done`  out  1: one-cycle pulse when the result is ready.
- `stall_count`  out  CNT_W: number of cycles with `stall`=1; saturates at all-ones.

## Operation
Dependency terms (combinational):
- `rs_dep` = `id_uses_rs` and `id_rs`≠0; `rt_dep` likewise for rt.
- `load_use` = `ex_mem_read` and `ex_rd` matches a dependent source.
- `br_ex` = (`id_is_branch` or jr) and `ex_reg_write` and `ex_rd`≠0 and `ex_rd` matches a dependent source.
- `br_mem` = (`id_is_branch` or jr) and `mem_mem_read` and `mem_rd` matches a dependent source.
- `md_hz` = `md_busy` and (`id_is_muldiv` or `id_reads_hilo`).
- `hz` = `load_use` or `br_ex` or `br_mem` or `md_hz`.

Outputs:
- `stall` = `id_ex_bubble` = `hz`.
- `redirect` = not `hz` and (`id_is_jump` or (`id_is_branch` and `id_branch_taken`)).
- `PCsrc` = `flush` = `redirect`.
- Priority: `hz` always wins; a branch is never resolved with stale operands.
- `stall` and `flush` are never both 1.

Mul/div FSM, states RUN and MD_BUSY; 4-bit down-counter `md_cnt`:
- RUN → MD_BUSY when `id_is_muldiv` and not `hz` (the issue). `md_cnt` ← MD_LAT.
- In MD_BUSY, `md_cnt` decrements each cycle. At `md_cnt`==1: `md_done`=1 and the next state is RUN.
- An issue in the same cycle as `md_done` is impossible, because `md_hz` stalls that instruction.
- `md_busy` = (state==MD_BUSY).

Counter:
- `stall_count` increments on every cycle with `stall`=1.
- It holds at 2^CNT_W−1.

Reset, including mid-operation:
- State returns to RUN, `md_cnt`=0, `stall_count`=0.
- Any in-flight mul/div is abandoned; no `md_done` pulse.

## Timing
- `stall`, `flush`, `PCsrc`, `id_ex_bubble`: combinational, same cycle as the inputs, zero latency.
- `md_busy`, `md_done`, `stall_count`: registered.
- Issue on edge T → `md_busy`=1 during cycles T+1..T+MD_LAT. `md_done`=1 in cycle T+MD_LAT. `md_busy`=0 from T+MD_LAT+1.
- An mfhi waiting in ID is released in the cycle after `md_done`.
- Reset values: all outputs 0.
- Load-use costs 1 stall cycle.
- A branch depending on the EX ALU result costs 1 stall; a branch depending on a load in EX costs 2 (EX, then MEM).

## Structure
- The shared package `pipeline_pkg` holds:
  - the FSM state typedef (RUN, MD_BUSY);
  - the `REG_ZERO` constant;
  - the MD_LAT default.
- Sub-module `hazard_detect`: purely combinational; computes `hz` and `redirect`.
- The top level holds the FSM, `md_cnt` and `stall_count`.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=8, `id_rs`=8, `id_uses_rs`=1 → `stall`=`id_ex_bubble`=1, `flush`=0, `stall_count` 0→1.
- $zero: same as above with `ex_rd`=`id_rs`=0 → `stall`=0.
- Taken branch, no hazard: `id_is_branch`=`id_branch_taken`=1 → `PCsrc`=`flush`=1, `stall`=0.
- Branch behind a load:
  - cycle 1: `ex_mem_read`=1, `ex_rd`=9, `id_rt`=9 → `stall`=1, `flush`=0;
  - cycle 2: `mem_mem_read`=1, `mem_rd`=9 → `stall`=1;
  - cycle 3: no hazard, taken → `flush`=1.
- Mul/div with MD_LAT=4:
  - issue at T → `md_busy` 1 for 4 cycles, `md_done` at T+4;
  - `id_reads_hilo` held → `stall`=1 through T+4, 0 at T+5.
- Reset mid-op: assert `reset` at T+2 of a mul/div → `md_busy`=0 and `stall_count`=0 immediately; no `md_done` pulse afterward.
